program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, program memory address width.
REQ-002 SHALL have parameter DATA_W, default 2, instruction word width (00 INC, 01 JNO, 10 HLT, 11 illegal).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a load session from IDLE, DONE or ERROR.
REQ-006 SHALL have port in_valid  input  1  host word valid.
REQ-007 SHALL have port in_data  input  DATA_W  host instruction word.
REQ-008 SHALL have port in_last  input  1  marks final word of the program.
REQ-009 SHALL have port in_ready  output  1  loader accepts the word this cycle.
REQ-010 SHALL have port mem_we  output  1  program RAM write strobe.
REQ-011 SHALL have port mem_addr  output  ADDR_W  RAM write/readback address.
REQ-012 SHALL have port mem_wdata  output  DATA_W  RAM write data.
REQ-013 SHALL have port mem_rdata  input  DATA_W  RAM combinational read data (used only with LOADER_VERIFY_EN).
REQ-014 SHALL have port status  output  1  0 = loader owns RAM and processor is held; 1 = processor released to run.
REQ-015 SHALL have port done  output  1  load completed successfully.
REQ-016 SHALL have port error  output  1  session aborted (illegal opcode, overflow or readback mismatch).
REQ-017 SHALL have port words  output  ADDR_W+1  number of words written this session.

Function
REQ-018 SHALL implement states IDLE, LOAD, VERIFY, DONE, ERROR.
REQ-019 SHALL move from IDLE/DONE/ERROR to LOAD on start, clearing words, write address, done and error the same edge.
REQ-020 SHALL assert in_ready only in LOAD; a word transfers when in_valid and in_ready are both 1.
REQ-021 SHALL, on a transfer, drive mem_we=1, mem_addr=current address, mem_wdata=in_data combinationally in that cycle, then increment address and words at the edge (latency 0 to RAM).
REQ-022 SHALL, on a transfer with in_data=11, suppress mem_we and enter ERROR.
REQ-023 SHALL, on a transfer with in_last=1, leave LOAD next edge (to VERIFY if enabled, else DONE).
REQ-024 SHALL, when the word at address 2^ADDR_W-1 is written with in_last=0, write it and enter ERROR (overflow); the address SHALL never wrap within a session.
REQ-025 SHALL ignore start while in LOAD or VERIFY.
REQ-026 SHALL hold status=0 in every state except DONE, where status=1.
REQ-027 SHALL hold done=1 only in DONE and error=1 only in ERROR.
REQ-028 SHALL keep mem_we=0 outside LOAD.

Reset
REQ-029 SHALL, on reset low, immediately enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, status=0, done=0, error=0, words=0, regardless of state.
REQ-030 SHALL, on reset mid-LOAD, discard the session; RAM contents already written are not rolled back.

Configuration
REQ-031 SHALL, with LOADER_VERIFY_EN defined, include VERIFY: readback addresses 0..words-1, one per cycle, compare mem_rdata with a shadow copy of written data; any mismatch -> ERROR, all match -> DONE.
REQ-032 SHALL, without LOADER_VERIFY_EN, omit VERIFY state and shadow storage; LOAD goes directly to DONE.

Structure
REQ-033 SHALL take opcode constants (INC, JNO, HLT, ILLEGAL) and state encodings from shared package paper_pkg.
REQ-034 SHALL be a single module except optional sub-module loader_shadow (written-word store) when LOADER_VERIFY_EN is defined.

Verification
REQ-035 SHALL cover: start, words 00,01,01,10 (last on 10), in_valid held -> writes addr0..3 on 4 consecutive cycles, words=4, done=1, status=1.
REQ-036 SHALL cover: in_valid toggling 1,0,1 on words 00,10(last) -> exactly 2 writes, addr 0 and 1, done=1.
REQ-037 SHALL cover: second word 11 -> one write only, error=1, status=0, mem_we never asserted for 11.
REQ-038 SHALL cover: 4 words with in_last=0 -> 4 writes, error=1, no write to addr 0 afterwards.
REQ-039 SHALL cover: reset low after second word -> next cycle all outputs at reset values; subsequent start reloads from addr 0.
REQ-040 SHALL cover (LOADER_VERIFY_EN): bench RAM corrupts addr 1 to 10 after load of 00,01,10 -> error=1, done=0.

Source files
------------

// File: rtl/paper_pkg.sv
// Shared opcode constants and loader state encoding.
package paper_pkg;

  localparam logic [1:0] OP_INC     = 2'b00;
  localparam logic [1:0] OP_JNO     = 2'b01;
  localparam logic [1:0] OP_HLT     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/loader_shadow.sv
// Shadow copy of every word written during a load, read back by the VERIFY pass.
// Only present when LOADER_VERIFY_EN is defined.
`ifdef LOADER_VERIFY_EN
module loader_shadow #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`endif

// File: rtl/program_loader.sv
// Streams host instruction words into program RAM, then releases the processor (status=1).
// Define LOADER_VERIFY_EN to add a readback pass comparing RAM against a shadow copy.
module program_loader
  import paper_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              status,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef LOADER_VERIFY_EN
  localparam state_e LOAD_EXIT = ST_VERIFY;
`else
  localparam state_e LOAD_EXIT = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              xfer, illegal;

  assign in_ready  = (state_q == ST_LOAD);
  assign xfer      = in_valid & in_ready;
  assign illegal   = (in_data == DATA_W'(OP_ILLEGAL));
  assign mem_we    = xfer & ~illegal;
  assign mem_wdata = mem_we ? in_data : '0;
  assign status    = (state_q == ST_DONE);
  assign done      = status;
  assign error     = (state_q == ST_ERROR);
  assign words     = words_q;

`ifdef LOADER_VERIFY_EN
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] shadow_rdata;
  logic              rd_last, rd_match;

  loader_shadow #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_shadow (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (in_data),
    .raddr_i (raddr_q),
    .rdata_o (shadow_rdata)
  );

  // words is never zero here: VERIFY is only entered after a successful write.
  assign rd_last  = (({1'b0, raddr_q} + (ADDR_W+1)'(1)) == words_q);
  assign rd_match = (mem_rdata == shadow_rdata);
  assign mem_addr = (state_q == ST_VERIFY) ? raddr_q : addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) raddr_q <= '0;
    else        raddr_q <= raddr_d;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_addr     = addr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
`ifdef LOADER_VERIFY_EN
    raddr_d = raddr_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          words_d = '0;
`ifdef LOADER_VERIFY_EN
          raddr_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (illegal) begin
            state_d = ST_ERROR;
          end else begin
            words_d = words_q + (ADDR_W+1)'(1);
            // Address saturates at the top so a session can never wrap onto word 0.
            if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
            if (in_last)                 state_d = LOAD_EXIT;
            else if (addr_q == ADDR_MAX) state_d = ST_ERROR;
          end
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_VERIFY: begin
        raddr_d = raddr_q + ADDR_W'(1);
        if (!rd_match)    state_d = ST_ERROR;
        else if (rd_last) state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized sessions against a session-level model.
module tb_program_loader;
  import paper_pkg::*;

  localparam int AW    = 2;
  localparam int DW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] mem_rdata;
  logic          in_ready, mem_we, status, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   words;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .status    (status),
    .done      (done),
    .error     (error),
    .words     (words)
  );

  // Bench-side program RAM with an optional read corruption for the readback scenario.
  logic [DW-1:0] ram [DEPTH];
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] corrupt_val = '0;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = (corrupt_en && mem_addr == corrupt_addr) ? corrupt_val : ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [AW-1:0] obs_a[$];
  logic [DW-1:0] obs_d[$];

  always @(negedge clk) begin
    if (mem_we) begin
      obs_a.push_back(mem_addr);
      obs_d.push_back(mem_wdata);
      chk("we_in_load", in_ready, 1);
      chk("we_not_illegal", (mem_wdata == OP_ILLEGAL), 0);
    end
  end

  logic [DW-1:0] w_d[8];
  bit            w_l[8];
  int            w_n;
  logic [DW-1:0] exp_q[$];
  bit            exp_done, exp_err;

  task automatic set_w(input int n, input logic [DW-1:0] d0, d1, d2, d3, input int last_at);
    w_n = n;
    w_d[0] = d0; w_d[1] = d1; w_d[2] = d2; w_d[3] = d3;
    for (int i = 0; i < 8; i++) w_l[i] = (i == last_at);
  endtask

  // Outcome of a session from the loading rules, word by word.
  task automatic model();
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i < w_n; i++) begin
      if (w_d[i] == OP_ILLEGAL) begin exp_err = 1'b1; break; end
      exp_q.push_back(w_d[i]);
      if (w_l[i])         begin exp_done = 1'b1; break; end
      if (i == DEPTH - 1) begin exp_err = 1'b1; break; end
    end
`ifdef LOADER_VERIFY_EN
    if (exp_done && corrupt_en && int'(corrupt_addr) < exp_q.size() &&
        corrupt_val != exp_q[corrupt_addr]) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end
`endif
  endtask

  task automatic pulse_start();
    obs_a.delete();
    obs_d.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_start", in_ready, 1);
    chk("words_cleared", words, 0);
  endtask

  // mode 0: valid held, 1: valid toggles 1,0,1..., 2: random valid
  task automatic drive_words(input int mode);
    int idx;
    int cyc;
    bit v;
    idx = 0;
    cyc = 0;
    while (idx < w_n && cyc < 100) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = w_d[idx];
      in_last  = w_l[idx];
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk("drv_bound", (cyc < 100), 1);
  endtask

  task automatic session(input int mode);
    model();
    pulse_start();
    drive_words(mode);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("n_writes", obs_a.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_a.size()) begin
        chk("wr_addr", obs_a[i], i);
        chk("wr_data", obs_d[i], exp_q[i]);
      end
    end
    chk("done", done, exp_done);
    chk("error", error, exp_err);
    chk("status", status, exp_done);
    chk("words", words, exp_q.size());
    chk("ready_idle", in_ready, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_status", status, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    bit has_last;
    #12;
    chk_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Four words with valid held, last on HLT at the top address.
    set_w(4, OP_INC, OP_JNO, OP_JNO, OP_HLT, 3);
    session(0);

    // Valid toggling: two writes only.
    set_w(2, OP_INC, OP_HLT, '0, '0, 1);
    session(1);

    // Illegal second word.
    set_w(2, OP_INC, OP_ILLEGAL, '0, '0, 1);
    session(0);

    // Overflow: no last within RAM depth.
    set_w(4, OP_INC, OP_JNO, OP_INC, OP_JNO, -1);
    session(0);

    // Reset mid-load after the second word, then reload from address 0.
    set_w(2, OP_INC, OP_JNO, '0, '0, -1);
    pulse_start();
    drive_words(0);
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    #2;
    reset = 1'b1;
    @(negedge clk);
    set_w(1, OP_HLT, '0, '0, '0, 0);
    session(0);

`ifdef LOADER_VERIFY_EN
    // Readback mismatch at address 1.
    corrupt_addr = 2'd1;
    corrupt_val  = OP_HLT;
    corrupt_en   = 1'b1;
    set_w(3, OP_INC, OP_JNO, OP_HLT, '0, 2);
    session(0);
    corrupt_en = 1'b0;
`endif

    for (int s = 0; s < 20; s++) begin
      has_last = ($urandom_range(0, 3) != 0);
      w_n = has_last ? int'($urandom_range(1, DEPTH)) : DEPTH;
      for (int i = 0; i < 8; i++) begin
        w_d[i] = ($urandom_range(0, 7) == 0) ? OP_ILLEGAL : DW'($urandom_range(0, 2));
        w_l[i] = has_last && (i == w_n - 1);
      end
      session(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
